// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        LOAD_STALL = 2'd1,
        BRANCH     = 2'd2,
        FREEZE     = 2'd3
    } action_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, sync active-high reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory freezes.
// Latch controls are combinational from registered state plus this cycle's inputs.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_addr_ID,
    input  logic [4:0]       rs2_addr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_EX,
    input  logic             RegWrite_EX,
    input  logic             DatatoReg_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IFID_flush,
    output logic             IDEX_EN,
    output logic             IDEX_flush,
    output logic             EXMEM_EN,
    output logic             MEMWB_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    action_t           action;
    logic              load_use;
    logic              mem_busy;

    assign load_use = RegWrite_EX && DatatoReg_EX && (rd_EX != REG_X0) &&
                      ((rs1_used_ID && (rs1_addr_ID == rd_EX)) ||
                       (rs2_used_ID && (rs2_addr_ID == rd_EX)));
    assign mem_busy = mem_req_MEM && !mem_ready;

    // A branch outranks load-use since the stalled ID instruction is squashed anyway.
    always_comb begin
        action = NORMAL;
        if (mem_busy)             action = FREEZE;
        else if (branch_taken_EX) action = BRANCH;
        else if (load_use)        action = LOAD_STALL;
    end

    always_comb begin
        PC_EN       = 1'b0;
        IFID_EN     = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_EN     = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_EN    = 1'b0;
        MEMWB_flush = 1'b0;
        if (!rst) begin
            case (action)
                FREEZE: MEMWB_flush = 1'b1;
                BRANCH: begin
                    PC_EN      = 1'b1;
                    IFID_EN    = 1'b1;
                    IFID_flush = 1'b1;
                    IDEX_EN    = 1'b1;
                    IDEX_flush = 1'b1;
                    EXMEM_EN   = 1'b1;
                end
                LOAD_STALL: begin
                    IDEX_EN    = 1'b1;
                    IDEX_flush = 1'b1;
                    EXMEM_EN   = 1'b1;
                end
                default: begin
                    PC_EN    = 1'b1;
                    IFID_EN  = 1'b1;
                    IDEX_EN  = 1'b1;
                    EXMEM_EN = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            default: begin
                if (mem_busy) begin
                    if (wait_cnt < WAIT_MAX) wait_cnt_next = wait_cnt + 1'b1;
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mem_timeout <= mem_timeout || (wait_cnt_next == WAIT_MAX);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((action == FREEZE) || (action == LOAD_STALL)),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (action == BRANCH),
        .count (flush_cnt)
    );

    a_freeze_holds_exmem: assert property (@(posedge clk) disable iff (rst)
        (action == FREEZE) |-> (!EXMEM_EN && MEMWB_flush && !PC_EN));

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with an expectation queue per step.
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    localparam int CNT_W = 8;

    // Output vector order: {PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_flush}
    localparam logic [6:0] O_NORM  = 7'b1101010;
    localparam logic [6:0] O_LOAD  = 7'b0001110;
    localparam logic [6:0] O_BR    = 7'b1111110;
    localparam logic [6:0] O_FRZ   = 7'b0000001;
    localparam logic [6:0] O_RST   = 7'b0000000;

    typedef struct {
        logic [6:0]       outs;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             tmo;
        state_t           st;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_addr_ID, rs2_addr_ID, rd_EX;
    logic rs1_used_ID, rs2_used_ID, RegWrite_EX, DatatoReg_EX;
    logic branch_taken_EX, mem_req_MEM, mem_ready;
    logic PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic mem_timeout;
    logic [6:0] obs;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign obs = {PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_flush};

    hazard_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_addr_ID     (rs1_addr_ID),
        .rs2_addr_ID     (rs2_addr_ID),
        .rs1_used_ID     (rs1_used_ID),
        .rs2_used_ID     (rs2_used_ID),
        .rd_EX           (rd_EX),
        .RegWrite_EX     (RegWrite_EX),
        .DatatoReg_EX    (DatatoReg_EX),
        .branch_taken_EX (branch_taken_EX),
        .mem_req_MEM     (mem_req_MEM),
        .mem_ready       (mem_ready),
        .PC_EN           (PC_EN),
        .IFID_EN         (IFID_EN),
        .IFID_flush      (IFID_flush),
        .IDEX_EN         (IDEX_EN),
        .IDEX_flush      (IDEX_flush),
        .EXMEM_EN        (EXMEM_EN),
        .MEMWB_flush     (MEMWB_flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout     (mem_timeout)
    );

    // Drive one cycle of inputs, check combinational controls mid-cycle and registered state after the edge.
    task automatic step(input string tag, input logic r,
                        input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic dr,
                        input logic br, input logic req, input logic rdy,
                        input logic [6:0] eo, input int es, input int ef, input logic et, input state_t est);
        exp_t e;
        rst = r; rs1_addr_ID = a1; rs1_used_ID = u1; rs2_addr_ID = a2; rs2_used_ID = u2;
        rd_EX = rd; RegWrite_EX = rw; DatatoReg_EX = dr;
        branch_taken_EX = br; mem_req_MEM = req; mem_ready = rdy;
        e.outs = eo; e.stall = CNT_W'(es); e.flush = CNT_W'(ef); e.tmo = et; e.st = est;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        total++;
        assert (obs === e.outs) else begin
            bad++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, e.outs);
        end
        @(posedge clk);
        #1;
        total++;
        assert (stall_cnt === e.stall) else begin
            bad++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, e.stall);
        end
        total++;
        assert (flush_cnt === e.flush) else begin
            bad++;
            $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, e.flush);
        end
        total++;
        assert (mem_timeout === e.tmo) else begin
            bad++;
            $error("FAIL %s mem_timeout observed=%b expected=%b", tag, mem_timeout, e.tmo);
        end
        total++;
        assert (dut.state === e.st) else begin
            bad++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, dut.state, e.st);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        //    tag          rst a1    u1 a2    u2 rd    rw dr br rq rdy exp     st fl to state
        step("reset",      1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_RST,  0, 0, 0, RUN);
        step("idle",       0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_NORM, 0, 0, 0, RUN);
        step("ld_use_rs1", 0, 5'd5, 1, 5'd2, 1, 5'd5, 1, 1, 0, 0, 0, O_LOAD, 1, 0, 0, RUN);
        step("after_ld",   0, 5'd5, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, O_NORM, 1, 0, 0, RUN);
        step("rd_x0",      0, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 0, 0, 0, O_NORM, 1, 0, 0, RUN);
        step("rs2_unused", 0, 5'd3, 1, 5'd7, 0, 5'd7, 1, 1, 0, 0, 0, O_NORM, 1, 0, 0, RUN);
        step("ld_use_rs2", 0, 5'd3, 1, 5'd7, 1, 5'd7, 1, 1, 0, 0, 0, O_LOAD, 2, 0, 0, RUN);
        step("br_over_ld", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 0, 0, O_BR,   2, 1, 0, RUN);
        step("zero_wait",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, O_NORM, 2, 1, 0, RUN);
        step("wait1",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ,  3, 1, 0, MEM_WAIT);
        step("wait2_br",   0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 1, 0, O_FRZ,  4, 1, 0, MEM_WAIT);
        step("wait3_br",   0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, O_FRZ,  5, 1, 0, MEM_WAIT);
        step("ready_br",   0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 1, O_BR,   5, 2, 0, RUN);
        step("post_wait",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_NORM, 5, 2, 0, RUN);
        step("to_w1",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ,  6, 2, 0, MEM_WAIT);
        step("to_w2",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ,  7, 2, 0, MEM_WAIT);
        step("to_w3",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ,  8, 2, 0, MEM_WAIT);
        step("to_w4",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ,  9, 2, 1, MEM_WAIT);
        step("to_w5",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 10, 2, 1, MEM_WAIT);
        step("to_w6",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 11, 2, 1, MEM_WAIT);
        step("to_rdy_ld",  0, 5'd9, 1, 5'd0, 0, 5'd9, 1, 1, 0, 1, 1, O_LOAD,12, 2, 1, RUN);
        step("to_sticky",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_NORM,12, 2, 1, RUN);
        step("rw_wait",    0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 13, 2, 1, MEM_WAIT);
        step("rst_in_wait",1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 1, 0, O_RST,  0, 0, 0, RUN);
        step("after_rst",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_NORM, 0, 0, 0, RUN);
        for (int i = 0; i < 260; i++) begin
            step("sat_stall", 0, 5'd4, 0, 5'd4, 1, 5'd4, 1, 1, 0, 0, 0, O_LOAD,
                 (i + 1 > 255) ? 255 : i + 1, 0, 0, RUN);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
